// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    // Result source selected by the memory stage
    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_PC4  = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    // Writeback FSM states
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    // Load size/sign encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // True when a load cannot be issued: reserved funct3 or misaligned address
    function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr);
        logic f;
        case (funct3)
            F3_LB, F3_LBU: f = 1'b0;
            F3_LH, F3_LHU: f = addr[0];
            F3_LW:         f = (addr != 2'b00);
            default:       f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Selects the addressed byte/halfword lane of a load word and extends it.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and sign/zero extension
    always_comb begin
        byte_sel = word[7:0];
        half_sel = word[15:0];
        data     = word;
        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the retiring result, waits for load data,
// and drives one registered register-file write plus a forwarding copy.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOAD_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_we,
    input  logic [1:0]       in_src,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [2:0]       in_funct3,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             err_load,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned TO_W = $clog2(LOAD_TIMEOUT) + 1;

    state_e            state;
    logic [4:0]        ld_rd;
    logic              ld_we;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_addr;
    logic [TO_W-1:0]   to_cnt;
    logic [XLEN-1:0]   ld_data;
    src_e              src;
    logic              accept;
    logic              fault;
    logic              nl_we;
    logic [XLEN-1:0]   nl_data;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign src      = src_e'(in_src);
    assign fault    = load_fault(in_funct3, in_alu[1:0]);

    // Write enable and data for non-load results (x0 and SRC_NONE never write)
    assign nl_we   = in_rd_we && (in_rd != 5'd0) && (src != SRC_NONE);
    assign nl_data = (src == SRC_PC4) ? (in_pc + XLEN'(4)) : in_alu;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3 (ld_funct3),
        .addr   (ld_addr),
        .word   (mem_rdata),
        .data   (ld_data)
    );

    // Forwarding port mirrors the registered write port
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

    // FSM, load capture, timeout counter, output registers and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ld_rd        <= 5'd0;
            ld_we        <= 1'b0;
            ld_funct3    <= 3'd0;
            ld_addr      <= 2'd0;
            to_cnt       <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= '0;
            err_load     <= 1'b0;
            retire_count <= '0;
        end else begin
            rf_we    <= 1'b0;
            err_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (src == SRC_LOAD) begin
                            if (fault) begin
                                err_load     <= 1'b1;
                                retire_count <= retire_count + CNT_W'(1);
                            end else begin
                                ld_rd     <= in_rd;
                                ld_we     <= in_rd_we && (in_rd != 5'd0);
                                ld_funct3 <= in_funct3;
                                ld_addr   <= in_alu[1:0];
                                to_cnt    <= '0;
                                state     <= WAIT_LOAD;
                            end
                        end else begin
                            retire_count <= retire_count + CNT_W'(1);
                            if (nl_we) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= in_rd;
                                rf_wdata <= nl_data;
                            end
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rvalid) begin
                        retire_count <= retire_count + CNT_W'(1);
                        state        <= IDLE;
                        if (ld_we) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ld_rd;
                            rf_wdata <= ld_data;
                        end
                    end else if (to_cnt == TO_W'(LOAD_TIMEOUT - 1)) begin
                        err_load     <= 1'b1;
                        retire_count <= retire_count + CNT_W'(1);
                        state        <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
